ifu32: RTL and testbench
========================

# ifu32

Instruction fetch unit for the GPC32 core. It sits directly upstream of the core's `inst` input. It accepts a fetch address from the PC side and issues one request at a time on a valid/ready memory request channel. It then captures the response and holds the instruction, its PC and a fault code until the core consumes them. A flush input discards in-flight work on redirects.

## Interface
- `INST_MAX`, 32: instruction width in bits.
- `WIDTH`, 32: address/PC width in bits.
- `NOP_INST`, 32'h0000_0013: value driven on `inst` when nothing valid is held or on a fault.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pc_valid`  in  1  fetch address offered.
- `pc`  in  WIDTH  fetch address.
- `pc_ready`  out  1  address accepted this cycle when high with `pc_valid`.
- `flush`  in  1  discard held or in-flight fetch.
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_addr`  out  WIDTH  request address (word aligned).
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_rsp_valid`  in  1  response valid, one cycle per accepted request.
- `mem_rsp_data`  in  INST_MAX  instruction word.
- `mem_rsp_err`  in  1  access error for this response.
- `inst_valid`  out  1  instruction held for the core.
- `inst`  out  INST_MAX  held instruction; `NOP_INST` when invalid or faulted.
- `inst_pc`  out  WIDTH  address of the held instruction.
- `inst_fault`  out  2  0 none, 1 misaligned (`pc[1:0]!=0`), 2 access error.
- `inst_ready`  in  1  core consumes the held instruction.

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN. At most one outstanding memory request.
- `pc_ready` = (IDLE or (HOLD and `inst_ready`)) and not `flush`.
- IDLE: on a `pc` handshake, latch `pc` into the address register.
  - If `pc[1:0]!=0`: go to HOLD with fault 1 and `inst=NOP_INST`. No bus access.
  - Otherwise go to REQ.
- REQ: `mem_req_valid=1` and `mem_req_addr` = latched address, held stable until `mem_req_ready`. On `mem_req_ready`, go to WAIT.
- WAIT: on `mem_rsp_valid`, go to HOLD.
  - `mem_rsp_err=0`: capture `mem_rsp_data`, fault 0.
  - `mem_rsp_err=1`: `inst=NOP_INST`, fault 2.
- HOLD: `inst_valid=1`; outputs stable until `inst_ready`.
  - On `inst_ready` with a new `pc` handshake in the same cycle, handle the new PC exactly as IDLE does (back-to-back).
  - On `inst_ready` alone, go to IDLE.
- Flush has highest priority. It blocks `pc` acceptance that cycle.
  - IDLE: no effect.
  - REQ: if `mem_req_ready` is high the same cycle, go to DRAIN; otherwise drop `mem_req_valid` and go to IDLE.
  - WAIT: if `mem_rsp_valid` is high the same cycle, discard it and go to IDLE; otherwise go to DRAIN.
  - HOLD: go to IDLE; `inst_valid` falls next cycle and the instruction is dropped.
  - DRAIN: stay in DRAIN.
- DRAIN: `pc_ready=0`, `mem_req_valid=0`. On `mem_rsp_valid`, discard the response and go to IDLE.
- `mem_rsp_valid` in IDLE, REQ or HOLD is a protocol violation. It is ignored, and the bench flags it with an assertion.

## Timing
- Reset values: state IDLE, `pc_ready=1` (subject to `flush`), `mem_req_valid=0`, `mem_req_addr=0`, `inst_valid=0`, `inst=NOP_INST`, `inst_pc=0`, `inst_fault=0`.
- Reset mid-operation aborts everything. Memory shares `rst`, so no orphan response is expected.
- All outputs are registered except `pc_ready`, which is combinational from state, `inst_ready` and `flush`.
- Latency, aligned fetch with memory ready and a 1-cycle response:
  - `pc` accepted at cycle N.
  - `mem_req_valid` high at N+1.
  - Response at N+2.
  - `inst_valid` at N+3.
- Misaligned fetch: `inst_valid` at N+1.
- Sustained throughput with a 1-cycle memory: one instruction per 3 cycles.
- `inst`, `inst_pc` and `inst_fault` change only on entry to HOLD.

## Test plan
- Reset, then `pc=0x8000_0000`, `mem_req_ready=1`, response `0x0010_0093` one cycle later -> `mem_req_addr=0x8000_0000` at N+1; `inst_valid` at N+3 with `inst=0x0010_0093`, `inst_pc=0x8000_0000`, fault 0.
- `pc=0x8000_0002` -> no `mem_req_valid`; `inst_valid` at N+1 with fault 1 and `inst=0x0000_0013`.
- `mem_rsp_err=1` on fetch of `0x8000_0004` -> HOLD with fault 2 and `inst=NOP_INST`.
- Backpressure:
  - `mem_req_ready` low for 4 cycles -> `mem_req_valid` and address stable throughout.
  - `inst_ready` low for 5 cycles -> `inst` and `inst_pc` stable.
  - Then `inst_ready` with a new `pc` in the same cycle -> new request the next cycle.
- Flush in WAIT, response 2 cycles later carrying `0xDEAD_BEEF` -> DRAIN; `pc_ready=0` until the response is discarded; `inst_valid` never rises for `0xDEAD_BEEF`.
- Async `rst` asserted mid-WAIT between clock edges -> all outputs reach reset values immediately; the first fetch after release behaves as in the first scenario.

Source files
------------

// File: rtl/ifu32_if.sv
// Signal bundle for the instruction fetch unit: PC offer, memory request/response
// channel and the instruction port toward the core.
interface ifu32_if #(
  parameter int WIDTH    = 32,
  parameter int INST_MAX = 32
);
  logic                pc_valid;
  logic [WIDTH-1:0]    pc;
  logic                pc_ready;
  logic                flush;
  logic                mem_req_valid;
  logic [WIDTH-1:0]    mem_req_addr;
  logic                mem_req_ready;
  logic                mem_rsp_valid;
  logic [INST_MAX-1:0] mem_rsp_data;
  logic                mem_rsp_err;
  logic                inst_valid;
  logic [INST_MAX-1:0] inst;
  logic [WIDTH-1:0]    inst_pc;
  logic [1:0]          inst_fault;
  logic                inst_ready;

  modport master (
    input  pc_valid, pc, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
           mem_rsp_err, inst_ready,
    output pc_ready, mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc,
           inst_fault
  );

  modport slave (
    output pc_valid, pc, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
           mem_rsp_err, inst_ready,
    input  pc_ready, mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc,
           inst_fault
  );
endinterface

// File: rtl/ifu32.sv
// Instruction fetch unit: one outstanding memory request at a time, holds the
// fetched instruction with its PC and fault code until the core takes it.
module ifu32 #(
  parameter int               INST_MAX = 32,
  parameter int               WIDTH    = 32,
  parameter logic [INST_MAX-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic     clk,
  input  logic     rst,
  ifu32_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0]    inst_pc_q, inst_pc_d;
  logic [INST_MAX-1:0] inst_q, inst_d;
  logic [1:0]          fault_q, fault_d;
  logic                req_valid_q, inst_valid_q;
  logic                pc_ready_s, pc_hs_s;

  assign pc_ready_s = ((state_q == S_IDLE) || ((state_q == S_HOLD) && bus.inst_ready))
                      && !bus.flush;
  assign pc_hs_s    = pc_ready_s && bus.pc_valid;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    inst_pc_d = inst_pc_q;
    inst_d    = inst_q;
    fault_d   = fault_q;
    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_REQ: begin
        if (bus.flush) begin
          state_d = bus.mem_req_ready ? S_DRAIN : S_IDLE;
        end else if (bus.mem_req_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (bus.mem_rsp_valid) begin
          if (bus.flush) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_HOLD;
            inst_d    = bus.mem_rsp_err ? NOP_INST : bus.mem_rsp_data;
            fault_d   = bus.mem_rsp_err ? 2'd2 : 2'd0;
            inst_pc_d = addr_q;
          end
        end else if (bus.flush) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (bus.flush || bus.inst_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      // A response that arrives while flush is still high is the one being waited for.
      S_DRAIN: state_d = bus.mem_rsp_valid ? S_IDLE : S_DRAIN;
      default: state_d = S_IDLE;
    endcase

    if (pc_hs_s) begin
      addr_d = bus.pc;
      if (bus.pc[1:0] != 2'b00) begin
        state_d   = S_HOLD;
        inst_d    = NOP_INST;
        fault_d   = 2'd1;
        inst_pc_d = bus.pc;
      end else begin
        state_d = S_REQ;
      end
    end

    if (state_d != S_HOLD) begin
      inst_d = NOP_INST;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      inst_pc_q    <= '0;
      inst_q       <= NOP_INST;
      fault_q      <= 2'd0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      inst_pc_q    <= inst_pc_d;
      inst_q       <= inst_d;
      fault_q      <= fault_d;
      req_valid_q  <= (state_d == S_REQ);
      inst_valid_q <= (state_d == S_HOLD);
    end
  end

  assign bus.pc_ready      = pc_ready_s;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = addr_q;
  assign bus.inst_valid    = inst_valid_q;
  assign bus.inst          = inst_q;
  assign bus.inst_pc       = inst_pc_q;
  assign bus.inst_fault    = fault_q;

endmodule

// File: tb/tb_ifu32.sv
// Self-checking bench for ifu32: directed scenarios plus randomized traffic against
// a transaction-level model of the fetch unit and a simple latency-programmable memory.
module tb_ifu32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifu32_if bus ();
  ifu32 dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the core should currently see and what the memory owes.
  bit          m_held, m_want, m_owed, m_keep;
  logic [31:0] m_addr, m_inst, m_ipc;
  logic [1:0]  m_fault;

  // Memory model.
  bit          mem_owed, rand_mem, mem_err;
  int          mem_cnt, mem_lat;
  logic [31:0] mem_word;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = 1'b0; m_want = 1'b0; m_owed = 1'b0; m_keep = 1'b0;
    m_addr = 32'h0; m_inst = NOP; m_ipc = 32'h0; m_fault = 2'd0;
    mem_owed = 1'b0; mem_cnt = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_pc_ready"},  bus.pc_ready, 32'd1);
    check_eq({tag, "_req_valid"}, bus.mem_req_valid, 32'd0);
    check_eq({tag, "_req_addr"},  bus.mem_req_addr, 32'h0);
    check_eq({tag, "_inst_valid"}, bus.inst_valid, 32'd0);
    check_eq({tag, "_inst"},      bus.inst, NOP);
    check_eq({tag, "_inst_pc"},   bus.inst_pc, 32'h0);
    check_eq({tag, "_fault"},     bus.inst_fault, 32'd0);
  endtask

  // One clock cycle: drive inputs, check pc_ready, advance model, check registered outputs.
  task automatic step(input bit pv, input logic [31:0] p, input bit fl, input bit rr, input bit ir);
    bit rsp, rerr, hs, acc, exp_rdy, held0, want0, owed0;
    logic [31:0] rdata;
    rsp   = mem_owed && (mem_cnt == 0);
    rdata = rand_mem ? $urandom : mem_word;
    rerr  = rand_mem ? ($urandom_range(0, 3) == 0) : mem_err;
    assert (!(rsp && !mem_owed)) else $error("memory responded with nothing outstanding");
    bus.pc_valid = pv; bus.pc = p; bus.flush = fl;
    bus.mem_req_ready = rr; bus.inst_ready = ir;
    bus.mem_rsp_valid = rsp; bus.mem_rsp_data = rdata; bus.mem_rsp_err = rerr;
    #1;
    exp_rdy = !fl && ((!m_held && !m_want && !m_owed) || (m_held && ir));
    check_eq("pc_ready", bus.pc_ready, exp_rdy);
    hs  = pv && exp_rdy;
    acc = bus.mem_req_valid && rr;

    if (rsp) mem_owed = 1'b0;
    else if (mem_owed) mem_cnt--;
    if (acc) begin
      mem_owed = 1'b1;
      mem_cnt  = rand_mem ? $urandom_range(0, 2) : mem_lat - 1;
    end

    held0 = m_held; want0 = m_want; owed0 = m_owed;
    if (held0 && (fl || ir)) m_held = 1'b0;
    if (owed0) begin
      if (rsp) begin
        m_owed = 1'b0;
        if (m_keep && !fl) begin
          m_held  = 1'b1;
          m_inst  = rerr ? NOP : rdata;
          m_fault = rerr ? 2'd2 : 2'd0;
          m_ipc   = m_addr;
        end
      end else if (fl) begin
        m_keep = 1'b0;
      end
    end
    if (want0) begin
      if (rr) begin
        m_want = 1'b0; m_owed = 1'b1; m_keep = !fl;
      end else if (fl) begin
        m_want = 1'b0;
      end
    end
    if (hs) begin
      m_addr = p;
      if (p[1:0] != 2'b00) begin
        m_held = 1'b1; m_inst = NOP; m_fault = 2'd1; m_ipc = p;
      end else begin
        m_want = 1'b1;
      end
    end

    @(posedge clk); #1;
    check_eq("req_valid", bus.mem_req_valid, m_want);
    check_eq("req_addr", bus.mem_req_addr, m_addr);
    check_eq("inst_valid", bus.inst_valid, m_held);
    check_eq("inst", bus.inst, m_held ? m_inst : NOP);
    check_eq("inst_pc", bus.inst_pc, m_ipc);
    check_eq("inst_fault", bus.inst_fault, m_fault);
  endtask

  task automatic fetch_first(input string tag);
    mem_lat = 1; mem_word = 32'h0010_0093; mem_err = 1'b0;
    step(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    check_eq({tag, "_req_n1"}, bus.mem_req_valid, 32'd1);
    check_eq({tag, "_addr_n1"}, bus.mem_req_addr, 32'h8000_0000);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check_eq({tag, "_nvalid_n2"}, bus.inst_valid, 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check_eq({tag, "_valid_n3"}, bus.inst_valid, 32'd1);
    check_eq({tag, "_inst_n3"}, bus.inst, 32'h0010_0093);
    check_eq({tag, "_pc_n3"}, bus.inst_pc, 32'h8000_0000);
    check_eq({tag, "_fault_n3"}, bus.inst_fault, 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    rand_mem = 1'b0; mem_lat = 1; mem_word = 32'h0; mem_err = 1'b0;
    bus.pc_valid = 1'b0; bus.pc = 32'h0; bus.flush = 1'b0; bus.mem_req_ready = 1'b0;
    bus.inst_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = 32'h0;
    bus.mem_rsp_err = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst = 1'b0;

    fetch_first("s1");

    // Misaligned fetch: fault 1, no bus access.
    step(1'b1, 32'h8000_0002, 1'b0, 1'b1, 1'b0);
    check_eq("mis_valid", bus.inst_valid, 32'd1);
    check_eq("mis_fault", bus.inst_fault, 32'd1);
    check_eq("mis_inst", bus.inst, NOP);
    check_eq("mis_noreq", bus.mem_req_valid, 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

    // Access error.
    mem_err = 1'b1; mem_word = 32'h1111_2222;
    step(1'b1, 32'h8000_0004, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check_eq("err_fault", bus.inst_fault, 32'd2);
    check_eq("err_inst", bus.inst, NOP);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    mem_err = 1'b0;

    // Request and hold backpressure, then back-to-back accept.
    mem_word = 32'h1234_5678;
    step(1'b1, 32'h8000_0008, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      check_eq("bp_req_stable", bus.mem_req_addr, 32'h8000_0008);
    end
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      check_eq("bp_inst_stable", bus.inst, 32'h1234_5678);
      check_eq("bp_pc_stable", bus.inst_pc, 32'h8000_0008);
    end
    step(1'b1, 32'h8000_000C, 1'b0, 1'b1, 1'b1);
    check_eq("b2b_req", bus.mem_req_valid, 32'd1);
    check_eq("b2b_addr", bus.mem_req_addr, 32'h8000_000C);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

    // Flush while waiting; late response must be discarded.
    mem_lat = 3; mem_word = 32'hDEAD_BEEF;
    step(1'b1, 32'h8000_0010, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h8000_0014, 1'b0, 1'b1, 1'b0);
    check_eq("drain_pc_ready", bus.pc_ready, 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check_eq("drain_no_valid", bus.inst_valid, 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check_eq("drain_no_valid2", bus.inst_valid, 32'd0);

    // Asynchronous reset in the middle of a wait.
    step(1'b1, 32'h8000_0020, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("arst");
    model_reset();
    #1 rst = 1'b0;
    @(posedge clk); #1;
    fetch_first("post_rst");

    // Randomized traffic.
    rand_mem = 1'b1;
    for (int i = 0; i < 800; i++) begin
      logic [31:0] r;
      logic [1:0]  lo;
      r  = $urandom;
      lo = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(1'($urandom_range(0, 1)), {r[31:2], lo}, ($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
